// File: rtl/pip_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : pip_issue_sched
// Brief    : Round-robin issue scheduler for the 4-stage 8-bit ADD/SUB
//            pipeline. Issues the opcode first and the operands one cycle
//            later. Each issued operation is tagged, so the pipeline result
//            is returned to the requester that sent it.
// Revision : 1.0 - initial release
// ============================================================================
module pip_issue_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          pp_instr,
  output logic [7:0]          pp_data_a,
  output logic [7:0]          pp_data_b,
  input  logic [7:0]          pp_result,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_data,
  output logic                idle,
  output logic [15:0]         issue_cnt
);

  localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0] r_rr;
  logic [IDW-1:0] w_rr_next;
  logic [NREQ-1:0] w_grant;
  logic           w_accept;
  logic [IDW-1:0] w_gid;
  logic [1:0]     w_op;
  logic [7:0]     w_a;
  logic [7:0]     w_b;
  logic [7:0]     r_hold_a;
  logic [7:0]     r_hold_b;
  logic [LAT:0]   r_tag_v;
  logic [IDW-1:0] r_tag_id [0:LAT];
  logic [15:0]    r_cnt;

  // Scan upward from the round-robin pointer and pick the first valid requester
  always_comb begin : p_arb
    int v_idx;
    v_idx    = 0;
    w_grant  = '0;
    w_accept = 1'b0;
    w_gid    = '0;
    w_op     = 2'b00;
    w_a      = 8'h00;
    w_b      = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_rr) + k;
      if (v_idx >= NREQ) begin
        v_idx = v_idx - NREQ;
      end
      if (!w_accept && cfg_en && req_valid[v_idx]) begin
        w_accept       = 1'b1;
        w_grant[v_idx] = 1'b1;
        w_gid          = IDW'(v_idx);
        w_op           = req_op[2*v_idx +: 2];
        w_a            = req_a[8*v_idx +: 8];
        w_b            = req_b[8*v_idx +: 8];
      end
    end
  end

  // The pointer moves to the slot after the requester just granted, wrapping at NREQ
  always_comb begin
    w_rr_next = (w_gid == c_LAST_ID) ? '0 : w_gid + 1'b1;
  end

  // Grants are masked while reset is asserted, so req_ready reads 0 during reset
  assign req_ready = w_grant & {NREQ{reset_n}};

  // Update the round-robin pointer and count accepted operations
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_rr  <= w_rr_next;
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Issue the opcode at accept; operands go through a hold stage one cycle behind
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_instr  <= 8'h00;
      r_hold_a  <= 8'h00;
      r_hold_b  <= 8'h00;
      pp_data_a <= 8'h00;
      pp_data_b <= 8'h00;
    end else begin
      pp_instr  <= w_accept ? {6'b000000, w_op} : 8'h00;
      r_hold_a  <= w_accept ? w_a : 8'h00;
      r_hold_b  <= w_accept ? w_b : 8'h00;
      pp_data_a <= r_hold_a;
      pp_data_b <= r_hold_b;
    end
  end

  // The tag pipe follows each operation through the pipeline latency to its response cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_v <= '0;
      for (int s = 0; s <= LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v     <= {r_tag_v[LAT-1:0], w_accept};
      r_tag_id[0] <= w_accept ? w_gid : '0;
      for (int s = 1; s <= LAT; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  assign rsp_valid = r_tag_v[LAT];
  assign rsp_id    = r_tag_id[LAT];
  assign rsp_data  = pp_result;
  assign idle      = ~|r_tag_v;
  assign issue_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pip_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pip_issue_sched
// Brief    : Self-checking bench for pip_issue_sched. Contains a behavioural
//            ADD/SUB pipeline and a cycle-indexed model of issue and response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pip_issue_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_en = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [2*NREQ-1:0] req_op = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        pp_instr, pp_data_a, pp_data_b, pp_result;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              idle;
  logic [15:0]       issue_cnt;

  pip_issue_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_en(cfg_en),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .pp_instr(pp_instr), .pp_data_a(pp_data_a),
    .pp_data_b(pp_data_b), .pp_result(pp_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .idle(idle), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural pipeline: instruction sampled first, operands one edge later,
  // result visible LAT edges after the instruction was sampled.
  logic [7:0] pl_ins, pl_s2, pl_s3, pl_s4;

  function automatic logic [7:0] alu(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
    case (ins)
      8'h01:   return a + b;
      8'h02:   return a - b;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pl_ins <= 8'h00; pl_s2 <= 8'h00; pl_s3 <= 8'h00; pl_s4 <= 8'h00;
    end else begin
      pl_ins <= pp_instr;
      pl_s2  <= alu(pl_ins, pp_data_a, pp_data_b);
      pl_s3  <= pl_s2;
      pl_s4  <= pl_s3;
    end
  end
  assign pp_result = pl_s4;

  // Reference model state: expectations keyed by absolute cycle number
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int m_rr = 0;
  int m_cnt = 0;
  int m_instr [int];
  int m_a [int];
  int m_b [int];
  int m_rid [int];
  int m_rdata [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]     = v;
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic clr_all();
    req_valid = '0;
  endtask

  // One clock cycle: check all outputs mid-cycle, then record what the edge accepts
  task automatic step();
    int g;
    int ev_idle;
    logic [NREQ-1:0] er;
    logic [1:0] op;
    logic [7:0] a, b;
    #2;
    g = -1;
    if (cfg_en) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    er = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("pp_instr", 32'(pp_instr), m_instr.exists(cyc) ? m_instr[cyc] : 0);
    chk("pp_data_a", 32'(pp_data_a), m_a.exists(cyc) ? m_a[cyc] : 0);
    chk("pp_data_b", 32'(pp_data_b), m_b.exists(cyc) ? m_b[cyc] : 0);
    chk("rsp_valid", 32'(rsp_valid), m_rid.exists(cyc) ? 1 : 0);
    if (m_rid.exists(cyc)) begin
      chk("rsp_id", 32'(rsp_id), m_rid[cyc]);
      chk("rsp_data", 32'(rsp_data), m_rdata[cyc]);
    end
    ev_idle = 1;
    for (int k = 0; k <= LAT; k++) begin
      if (m_rid.exists(cyc + k)) ev_idle = 0;
    end
    chk("idle", 32'(idle), ev_idle);
    chk("issue_cnt", 32'(issue_cnt), m_cnt & 32'hFFFF);
    @(posedge clk);
    if (g >= 0) begin
      op = req_op[2*g +: 2];
      a  = req_a[8*g +: 8];
      b  = req_b[8*g +: 8];
      m_instr[cyc+1]     = int'(op);
      m_a[cyc+2]         = int'(a);
      m_b[cyc+2]         = int'(b);
      m_rid[cyc+1+LAT]   = g;
      m_rdata[cyc+1+LAT] = (op == 2'b01) ? ((int'(a) + int'(b)) % 256)
                         : (op == 2'b10) ? ((int'(a) - int'(b) + 256) % 256) : 0;
      m_rr  = (g + 1) % NREQ;
      m_cnt = m_cnt + 1;
    end
    cyc++;
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous values, then hold for two edges
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_pp_instr", 32'(pp_instr), 0);
    chk("rst_pp_data_a", 32'(pp_data_a), 0);
    chk("rst_pp_data_b", 32'(pp_data_b), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_issue_cnt", 32'(issue_cnt), 0);
    m_instr.delete(); m_a.delete(); m_b.delete(); m_rid.delete(); m_rdata.delete();
    m_rr = 0;
    m_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    clr_all();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset with every requester asking, to see grants masked during reset
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b01, 8'h11, 8'h22);
    #2;
    do_reset();
    repeat (2) step();

    // Single ADD: 5 + 3 from requester 0
    set_req(0, 1'b1, 2'b01, 8'd5, 8'd3);
    step();
    clr_all();
    repeat (7) step();

    // Wrapping SUB and ADD
    set_req(2, 1'b1, 2'b10, 8'd3, 8'd5);
    step();
    clr_all();
    set_req(1, 1'b1, 2'b01, 8'd200, 8'd100);
    step();
    clr_all();
    repeat (7) step();

    // Fairness: everyone requests for 8 cycles
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'((i % 2) + 1), 8'(i * 40 + 7), 8'(i + 1));
    repeat (8) step();
    clr_all();
    repeat (6) step();

    // Sparse round robin, then a lone requester 0
    set_req(1, 1'b1, 2'b01, 8'd10, 8'd20);
    set_req(3, 1'b1, 2'b10, 8'd50, 8'd60);
    repeat (4) step();
    clr_all();
    set_req(0, 1'b1, 2'b01, 8'd1, 8'd1);
    step();
    clr_all();
    repeat (6) step();

    // Drain: three accepts, then grants disabled while requests stay up
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 2'b01, 8'(i + 100), 8'(i));
    repeat (3) step();
    cfg_en = 1'b0;
    repeat (8) step();
    cfg_en = 1'b1;
    clr_all();
    step();

    // Illegal opcode still yields a response of zero
    set_req(0, 1'b1, 2'b11, 8'd9, 8'd9);
    step();
    clr_all();
    repeat (6) step();

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      cfg_en = ($urandom % 6) != 0;
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 1'($urandom % 2), 2'($urandom % 4), 8'($urandom), 8'($urandom));
      end
      step();
    end
    cfg_en = 1'b1;
    clr_all();
    repeat (6) step();

    // Reset while operations are in flight: their responses must vanish
    set_req(0, 1'b1, 2'b01, 8'd1, 8'd2);
    set_req(1, 1'b1, 2'b10, 8'd7, 8'd1);
    repeat (2) step();
    clr_all();
    repeat (2) step();
    do_reset();
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pip_issue_sched.md
# pip_issue_sched

Issue scheduler for the 4-stage 8-bit ADD/SUB pipeline. Arbitrates round-robin among NREQ requesters, drives the pipeline's instruction and operand inputs with correct stage skew (operands one cycle behind instruction), and tags each issued operation so the pipeline result returns to the originating requester. Sits between the requester ports and the pipeline instance in the datapath top level.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-id width, ≥ clog2(NREQ)
- LAT, 4, pipeline latency in clock edges from instruction-sample edge to result visible

Ports:
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- Single clock `clk`; reset `reset_n` is asynchronous and active-low.
- cfg_en  in  1  grant enable; 0 stops new grants
- req_valid  in  NREQ  per-requester request
- req_op  in  2*NREQ  per-requester opcode; 01 ADD, 10 SUB
- req_a  in  8*NREQ  per-requester operand A
- req_b  in  8*NREQ  per-requester operand B
- req_ready  out  NREQ  one-hot grant; accept when valid&ready at posedge
- pp_instr  out  8  to pipeline instruction input
- pp_data_a  out  8  to pipeline operand A
- pp_data_b  out  8  to pipeline operand B
- pp_result  in  8  pipeline result
- rsp_valid  out  1  response valid, single cycle, no backpressure
- rsp_id  out  IDW  requester index of response
- rsp_data  out  8  response data (= pp_result)
- idle  out  1  no operation in flight
- issue_cnt  out  16  accepted-operation count

## Operation
- Arbitration: each cycle, if cfg_en=1, grant the first asserted req_valid at or after pointer `rr`, scanning upward mod NREQ. req_ready is one-hot, combinational from req_valid, rr and cfg_en. At most one acceptance per cycle.
- On acceptance of requester i: `rr` ← (i+1) mod NREQ. With no acceptance, `rr` holds.
- Issue register: at the accept edge, pp_instr ← {6'b0, req_op[i]}. Operands are latched into a hold register. One edge later they are driven to pp_data_a/pp_data_b.
- With no accept, pp_instr ← 0 (NOP). With no accept on the previous cycle, pp_data_a/b ← 0.
- Illegal opcodes (00, 11) are accepted and issued unchanged. The pipeline returns 0, and the response is still delivered.
- Tag pipe: LAT+1 stages of {valid, id}. Stage 0 loads at the accept edge and the pipe shifts every edge.
- rsp_valid/rsp_id come from the last stage. rsp_data = pp_result combinationally.
- idle = 1 when all tag-pipe valid bits are 0.
- issue_cnt increments on each acceptance and wraps at 16 bits.
- cfg_en=0: req_ready=0. In-flight operations still complete and respond. Deasserting cfg_en is the drain mechanism: wait for idle=1.
- Arithmetic is mod 256, performed by the pipeline. No overflow flag.

## Timing
- Reset (reset_n=0, async) values: req_ready=0, pp_instr=0, pp_data_a=0, pp_data_b=0, rsp_valid=0, rsp_id=0, idle=1, issue_cnt=0, rr=0. All tag stages invalid.
- Accept at the end of cycle t:
  - pp_instr valid in cycle t+1
  - pp_data_a/b valid in cycle t+2
  - rsp_valid=1 with result in cycle t+1+LAT (t+5 for LAT=4)
- Throughput: one op per cycle. Back-to-back accepts give back-to-back responses in the same order.
- Reset mid-operation: all in-flight tags are discarded and no responses are produced for them. The pipeline shares the same reset.
- Simultaneous accept and response in one cycle is legal and independent.

## Test plan
- Single op: req0 ADD a=5 b=3 accepted cycle 10 -> pp_instr=01 in cycle 11, pp_data_a=5/pp_data_b=3 in cycle 12, rsp_valid=1 rsp_id=0 rsp_data=8 in cycle 15 only.
- Wrap arithmetic: req2 SUB a=3 b=5 -> rsp_id=2 rsp_data=0xFE. req1 ADD a=200 b=100 -> rsp_data=0x2C.
- Fairness: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3 and responses in the same id order on 8 consecutive cycles; issue_cnt=8.
- Sparse round-robin: only req1 and req3 valid, rr=0 -> grants 1,3,1,3. Then req0 valid alone -> granted the next cycle.
- Drain: 3 back-to-back accepts, then cfg_en=0 -> req_ready=0 despite valid; 3 responses still arrive; idle=1 the cycle after the last response.
- Illegal op and reset: req0 op=11 a=9 b=9 -> rsp_data=0. Then accept 2 ops, assert reset_n=0 two cycles later -> no rsp_valid, idle=1, issue_cnt=0 immediately.
